// File: rtl/synth_pkg.sv
// Shared definitions for the tone-synth control path: opcodes, FSM states,
// FCW/glide widths and waveform-select encodings.
package synth_pkg;

    localparam int FCW_W  = 24;
    localparam int STEP_W = 12;
    localparam int CMD_W  = 16;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_FCW_HI = 4'h1;
    localparam logic [3:0] OP_FCW_LO = 4'h2;
    localparam logic [3:0] OP_GLIDE  = 4'h3;
    localparam logic [3:0] OP_WAVE   = 4'h4;
    localparam logic [3:0] OP_MUTE   = 4'h5;
    localparam logic [3:0] OP_COMMIT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_GLIDE = 2'd2
    } state_t;

    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_NOISE  = 2'd3;

    function automatic logic opcode_known(input logic [3:0] op);
        logic known;
        case (op)
            OP_NOP, OP_FCW_HI, OP_FCW_LO, OP_GLIDE,
            OP_WAVE, OP_MUTE, OP_COMMIT: known = 1'b1;
            default:                     known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/synth_ctrl_if.sv
// Command handshake between the SPI receiver (master) and synth_ctrl (slave).
interface synth_ctrl_if;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic        cmd_ready;
    logic        cmd_err;

    modport master (output cmd_valid, output cmd_data, input cmd_ready, input cmd_err);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready, output cmd_err);
endinterface

// File: rtl/synth_ctrl_fcw_glide.sv
// Combinational glide step: moves cur toward tgt by step without overshoot,
// flagging when the result lands exactly on the target.
module fcw_glide #(
    parameter int FCW_W  = synth_pkg::FCW_W,
    parameter int STEP_W = synth_pkg::STEP_W
) (
    input  logic [FCW_W-1:0]  cur,
    input  logic [FCW_W-1:0]  tgt,
    input  logic [STEP_W-1:0] step,
    output logic [FCW_W-1:0]  nxt,
    output logic              reached
);

    logic [FCW_W:0] cur_x_s;
    logic [FCW_W:0] tgt_x_s;
    logic [FCW_W:0] step_x_s;
    logic [FCW_W:0] dist_s;
    logic           up_s;

    // Distance and direction on one extra bit so neither the compare nor the step can wrap.
    always_comb begin
        cur_x_s  = {1'b0, cur};
        tgt_x_s  = {1'b0, tgt};
        step_x_s = {{(FCW_W+1-STEP_W){1'b0}}, step};
        up_s     = (tgt_x_s > cur_x_s);
        if (up_s) begin
            dist_s = tgt_x_s - cur_x_s;
        end else begin
            dist_s = cur_x_s - tgt_x_s;
        end
        reached = (dist_s <= step_x_s);
        if (reached) begin
            nxt = tgt;
        end else if (up_s) begin
            nxt = cur + step_x_s[FCW_W-1:0];
        end else begin
            nxt = cur - step_x_s[FCW_W-1:0];
        end
    end

endmodule

// File: rtl/synth_ctrl.sv
// Command-driven tone controller: decodes SPI command words into shadow
// registers and applies FCW on sample ticks (with glide) and wave/mute on phase wraps.
module synth_ctrl #(
    parameter int FCW_W  = synth_pkg::FCW_W,
    parameter int STEP_W = synth_pkg::STEP_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    synth_ctrl_if.slave      cmd,
    input  logic             i_sample_tick,
    input  logic             i_phase_wrap,
    output logic [FCW_W-1:0] o_fcw,
    output logic [1:0]       o_wave_sel,
    output logic             o_mute,
    output logic             o_glide_active
);
    import synth_pkg::*;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [FCW_W-1:0]   fcw_r;
    logic [FCW_W-1:0]   fcw_nxt_s;
    logic [FCW_W-1:0]   target_r;
    logic [FCW_W-1:0]   shadow_fcw_r;
    logic [STEP_W-1:0]  step_r;
    logic [1:0]         shadow_wave_r;
    logic               shadow_mute_r;
    logic               wave_pend_r;
    logic [1:0]         wave_r;
    logic               mute_r;
    logic               ready_r;
    logic               err_r;
    logic               glide_r;

    logic [3:0]         op_s;
    logic [11:0]        pay_s;
    logic               accept_s;
    logic               commit_fcw_s;
    logic               commit_wave_s;
    logic               err_nxt_s;
    logic [FCW_W-1:0]   glide_nxt_s;
    logic               glide_reached_s;

    assign op_s          = cmd.cmd_data[15:12];
    assign pay_s         = cmd.cmd_data[11:0];
    assign accept_s      = cmd.cmd_valid & ready_r;
    assign commit_fcw_s  = accept_s & (op_s == OP_COMMIT) & pay_s[0];
    assign commit_wave_s = accept_s & (op_s == OP_COMMIT) & pay_s[1];
    assign err_nxt_s     = (cmd.cmd_valid & ~ready_r) | (accept_s & ~opcode_known(op_s));

    assign cmd.cmd_ready  = ready_r;
    assign cmd.cmd_err    = err_r;
    assign o_fcw          = fcw_r;
    assign o_wave_sel     = wave_r;
    assign o_mute         = mute_r;
    assign o_glide_active = glide_r;

    fcw_glide #(
        .FCW_W  (FCW_W),
        .STEP_W (STEP_W)
    ) u_fcw_glide (
        .cur     (fcw_r),
        .tgt     (target_r),
        .step    (step_r),
        .nxt     (glide_nxt_s),
        .reached (glide_reached_s)
    );

    // Next-state and next-FCW decode for the IDLE/ARM/GLIDE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        fcw_nxt_s   = fcw_r;
        case (state_r)
            ST_IDLE: begin
                if (commit_fcw_s) begin
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (i_sample_tick) begin
                    if ((step_r == {STEP_W{1'b0}}) || (target_r == fcw_r)) begin
                        fcw_nxt_s   = target_r;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        fcw_nxt_s   = glide_nxt_s;
                        state_nxt_s = glide_reached_s ? ST_IDLE : ST_GLIDE;
                    end
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_GLIDE: begin
                if (i_sample_tick) begin
                    fcw_nxt_s   = glide_nxt_s;
                    state_nxt_s = glide_reached_s ? ST_IDLE : ST_GLIDE;
                end else begin
                    state_nxt_s = ST_GLIDE;
                end
                // A retarget keeps gliding even if this tick lands on the old target.
                if (commit_fcw_s) begin
                    state_nxt_s = ST_GLIDE;
                end else begin
                    state_nxt_s = state_nxt_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                fcw_nxt_s   = fcw_r;
            end
        endcase
    end

    // Sequencer state, live FCW, target and the state-decoded handshake outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            fcw_r    <= {FCW_W{1'b0}};
            target_r <= {FCW_W{1'b0}};
            ready_r  <= 1'b1;
            glide_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            fcw_r    <= fcw_nxt_s;
            ready_r  <= (state_nxt_s != ST_ARM);
            glide_r  <= (state_nxt_s == ST_GLIDE);
            err_r    <= err_nxt_s;
            if (commit_fcw_s) begin
                target_r <= shadow_fcw_r;
            end
        end
    end

    // Shadow registers written by accepted configuration commands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_fcw_r  <= {FCW_W{1'b0}};
            step_r        <= {STEP_W{1'b0}};
            shadow_wave_r <= WAVE_SINE;
            shadow_mute_r <= 1'b0;
        end else if (accept_s) begin
            case (op_s)
                OP_FCW_HI: shadow_fcw_r[FCW_W-1 -: 12] <= pay_s;
                OP_FCW_LO: shadow_fcw_r[11:0]          <= pay_s;
                OP_GLIDE:  step_r                      <= pay_s[STEP_W-1:0];
                OP_WAVE:   shadow_wave_r               <= pay_s[1:0];
                OP_MUTE:   shadow_mute_r               <= pay_s[0];
                default:   shadow_fcw_r                <= shadow_fcw_r;
            endcase
        end
    end

    // Wave/mute commit: armed by COMMIT bit1, applied on the next phase wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wave_pend_r <= 1'b0;
            wave_r      <= WAVE_SINE;
            mute_r      <= 1'b1;
        end else begin
            if (i_phase_wrap && wave_pend_r) begin
                wave_r <= shadow_wave_r;
                mute_r <= shadow_mute_r;
            end
            if (commit_wave_s) begin
                wave_pend_r <= 1'b1;
            end else if (i_phase_wrap) begin
                wave_pend_r <= 1'b0;
            end
        end
    end

endmodule
